stopwatch_datapath: RTL and testbench

Counting and display engine driven by the stopwatch/timer controller FSM. It holds the 0.00–99.99 s count in BCD and latches the start/limit value. It steps the count up or down on a 10 ms tick, raises the terminal-count flag, and multiplexes the four-digit seven-segment display. It is the command-receiving end of the controller's `init_ld_en / count_en / ctr_select / tc_select / an_reset` interface.

---
 rtl/stopwatch_datapath.sv | 178 +++++++++++++++++
 tb/tb_stopwatch_datapath.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_datapath.sv
// Counting and display engine for the stopwatch/timer controller: BCD count,
// limit register, 10 ms prescaler, terminal-count flag and 7-segment scan.
module stopwatch_datapath #(
    parameter int unsigned CLK_HZ         = 100_000_000,
    parameter int unsigned TICK_HZ        = 100,
    parameter int unsigned REFRESH_CYCLES = 100_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        init_ld_en,
    input  logic        count_en,
    input  logic [2:0]  ctr_select,
    input  logic        tc_select,
    input  logic [16:0] init_val,
    input  logic        an_reset,
    output logic        tc_limit_reached,
    output logic [3:0]  an,
    output logic [6:0]  sseg,
    output logic [16:0] synch_init
);
    localparam int unsigned VAL_W    = 17;
    localparam int unsigned BIN_W    = 14;
    localparam int unsigned BCD_W    = 16;
    localparam int unsigned MAX_VAL  = 9999;
    localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PS_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned RC_W     = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    function automatic logic [BCD_W-1:0] to_bcd(input logic [BIN_W-1:0] v);
        int unsigned t;
        t = 32'(v);
        return {4'(t / 1000), 4'((t / 100) % 10), 4'((t / 10) % 10), 4'(t % 10)};
    endfunction

    function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        logic             carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [BCD_W-1:0] bcd_dec(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        logic             borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (r[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    logic [VAL_W-1:0] limit_q, limit_d;
    logic [BCD_W-1:0] limit_bcd_q, limit_bcd_d;
    logic [BCD_W-1:0] count_q, count_d;
    logic [PS_W-1:0]  ps_q, ps_d;
    logic [RC_W-1:0]  ref_q, ref_d;
    logic [1:0]       digit_idx_q, digit_idx_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       sseg_q, sseg_d;

    logic [BIN_W-1:0] clamp_c;
    logic [BCD_W-1:0] init_bcd_c;
    logic [BCD_W-1:0] ceiling_c;
    logic [3:0]       digit_c;
    logic             counting_c;
    logic             tick_c;

    // Limit register and count/prescaler next state
    always_comb begin
        clamp_c    = (init_val > VAL_W'(MAX_VAL)) ? BIN_W'(MAX_VAL) : init_val[BIN_W-1:0];
        init_bcd_c = to_bcd(clamp_c);
        ceiling_c  = tc_select ? BCD_W'(16'h9999) : limit_bcd_q;
        counting_c = count_en && (ctr_select == 3'd1 || ctr_select == 3'd2);
        tick_c     = counting_c && (ps_q == PS_W'(TICK_DIV - 1));

        limit_d     = limit_q;
        limit_bcd_d = limit_bcd_q;
        count_d     = count_q;
        ps_d        = ps_q;

        if (init_ld_en) begin
            limit_d     = {3'b000, clamp_c};
            limit_bcd_d = init_bcd_c;
        end

        if (count_en && (ctr_select == 3'd0 || ctr_select == 3'd3)) begin
            ps_d = '0;
        end else if (counting_c) begin
            ps_d = tick_c ? '0 : ps_q + PS_W'(1);
        end

        if (count_en) begin
            case (ctr_select)
                3'd0: count_d = init_bcd_c;
                3'd1: if (tick_c && count_q < ceiling_c) count_d = bcd_inc(count_q);
                3'd2: if (tick_c && count_q != '0) count_d = bcd_dec(count_q);
                3'd3: count_d = '0;
                default: count_d = count_q;
            endcase
        end
    end

    // Display scan; anode and segments registered together from digit_idx
    always_comb begin
        ref_d       = (ref_q == RC_W'(REFRESH_CYCLES - 1)) ? '0 : ref_q + RC_W'(1);
        digit_idx_d = (ref_q == RC_W'(REFRESH_CYCLES - 1)) ? digit_idx_q + 2'd1 : digit_idx_q;
        case (digit_idx_q)
            2'd0:    digit_c = count_q[3:0];
            2'd1:    digit_c = count_q[7:4];
            2'd2:    digit_c = count_q[11:8];
            default: digit_c = count_q[15:12];
        endcase
        an_d   = an_reset ? 4'b1111 : ~(4'b0001 << digit_idx_q);
        sseg_d = an_reset ? 7'b1111111 : seg_code(digit_c);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            limit_q     <= VAL_W'(MAX_VAL);
            limit_bcd_q <= BCD_W'(16'h9999);
            count_q     <= '0;
            ps_q        <= '0;
            ref_q       <= '0;
            digit_idx_q <= '0;
            an_q        <= 4'b1111;
            sseg_q      <= 7'b1111111;
        end else begin
            limit_q     <= limit_d;
            limit_bcd_q <= limit_bcd_d;
            count_q     <= count_d;
            ps_q        <= ps_d;
            ref_q       <= ref_d;
            digit_idx_q <= digit_idx_d;
            an_q        <= an_d;
            sseg_q      <= sseg_d;
        end
    end

    assign tc_limit_reached = tc_select ? (count_q == '0) : (count_q == limit_bcd_q);
    assign an               = an_q;
    assign sseg             = sseg_q;
    assign synch_init       = limit_q;
endmodule

// File: tb/tb_stopwatch_datapath.sv
// Directed bench for stopwatch_datapath: reset, timer, stopwatch, BCD carries,
// pause/resume, display scan, clamp and asynchronous reset.
module tb_stopwatch_datapath;
    logic        clk = 1'b0;
    logic        reset;
    logic        init_ld_en;
    logic        count_en;
    logic [2:0]  ctr_select;
    logic        tc_select;
    logic [16:0] init_val;
    logic        an_reset;
    logic        tc_limit_reached;
    logic [3:0]  an;
    logic [6:0]  sseg;
    logic [16:0] synch_init;

    int n_checks = 0;
    int n_fail   = 0;
    int edges;

    stopwatch_datapath #(
        .CLK_HZ(1000), .TICK_HZ(100), .REFRESH_CYCLES(4)
    ) dut (
        .clk(clk), .reset(reset), .init_ld_en(init_ld_en), .count_en(count_en),
        .ctr_select(ctr_select), .tc_select(tc_select), .init_val(init_val),
        .an_reset(an_reset), .tc_limit_reached(tc_limit_reached), .an(an),
        .sseg(sseg), .synch_init(synch_init)
    );

    always #5 clk = ~clk;

    // Clock edges seen since the last reset release
    always @(posedge clk or negedge reset) begin
        if (!reset) edges <= 0;
        else        edges <= edges + 1;
    end

    function automatic logic [6:0] exp_seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_count(input string tag, input logic [15:0] exp);
        chk(tag, 32'(dut.count_q), 32'(exp));
    endtask

    initial begin
        int d;
        int digs [4];
        reset = 1'b0; init_ld_en = 1'b0; count_en = 1'b0; ctr_select = 3'd7;
        tc_select = 1'b0; init_val = '0; an_reset = 1'b0;

        // Reset state
        #23;
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_sseg", 32'(sseg), 32'h7F);
        chk("rst_synch_init", 32'(synch_init), 32'd9999);
        chk("rst_tc_sw", 32'(tc_limit_reached), 32'd0);
        tc_select = 1'b1; #1;
        chk("rst_tc_timer", 32'(tc_limit_reached), 32'd1);
        tc_select = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;

        // Scan with zero count over three-plus refresh periods
        for (int k = 1; k <= 16; k++) begin
            step(1);
            d = ((k - 1) / 4) % 4;
            chk("scan0_an", 32'(an), 32'(~(4'b0001 << d) & 4'hF));
            chk("scan0_sseg", 32'(sseg), 32'h40);
        end

        // Timer: load 1200 then count down
        init_val = 17'd1200; init_ld_en = 1'b1; ctr_select = 3'd0; count_en = 1'b1;
        tc_select = 1'b1;
        step(1);
        chk("tmr_synch_init", 32'(synch_init), 32'd1200);
        chk_count("tmr_load", 16'h1200);
        chk("tmr_tc_load", 32'(tc_limit_reached), 32'd0);
        init_ld_en = 1'b0; ctr_select = 3'd2;
        step(9);
        chk_count("tmr_before_tick", 16'h1200);
        step(1);
        chk_count("tmr_first_tick", 16'h1199);
        step(11989);
        chk_count("tmr_one_left", 16'h0001);
        chk("tmr_tc_one_left", 32'(tc_limit_reached), 32'd0);
        step(1);
        chk_count("tmr_zero", 16'h0000);
        chk("tmr_tc_zero", 32'(tc_limit_reached), 32'd1);
        step(1000);
        chk_count("tmr_hold_zero", 16'h0000);
        chk("tmr_tc_hold", 32'(tc_limit_reached), 32'd1);

        // Async reset mid-down-count at 0500
        init_val = 17'd500; ctr_select = 3'd0;
        step(1);
        chk_count("ar_load", 16'h0500);
        ctr_select = 3'd2;
        step(5);
        #1 reset = 1'b0;
        #1;
        chk_count("ar_count", 16'h0000);
        chk("ar_an", 32'(an), 32'hF);
        chk("ar_sseg", 32'(sseg), 32'h7F);
        chk("ar_synch_init", 32'(synch_init), 32'd9999);
        @(posedge clk); #1;
        reset = 1'b1;

        // Stopwatch up to limit 300
        init_val = 17'd300; init_ld_en = 1'b1; ctr_select = 3'd3; count_en = 1'b1;
        tc_select = 1'b0;
        step(1);
        chk("sw_synch_init", 32'(synch_init), 32'd300);
        chk_count("sw_clear", 16'h0000);
        init_ld_en = 1'b0; ctr_select = 3'd1;
        step(2999);
        chk_count("sw_299", 16'h0299);
        chk("sw_tc_299", 32'(tc_limit_reached), 32'd0);
        step(1);
        chk_count("sw_300", 16'h0300);
        chk("sw_tc_300", 32'(tc_limit_reached), 32'd1);
        step(100);
        chk_count("sw_sat", 16'h0300);

        // Clamp and saturation at 9999
        init_val = 17'd12000; init_ld_en = 1'b1; ctr_select = 3'd0;
        step(1);
        chk("clamp_synch_init", 32'(synch_init), 32'd9999);
        chk_count("clamp_count", 16'h9999);
        init_ld_en = 1'b0; ctr_select = 3'd1;
        step(20);
        chk_count("sat_9999", 16'h9999);
        chk("sat_tc", 32'(tc_limit_reached), 32'd1);

        // BCD carries 0099->0100 and 0999->1000
        init_val = 17'd98; ctr_select = 3'd0;
        step(1);
        ctr_select = 3'd1;
        step(20);
        chk_count("carry_0100", 16'h0100);
        init_val = 17'd998; ctr_select = 3'd0;
        step(1);
        ctr_select = 3'd1;
        step(20);
        chk_count("carry_1000", 16'h1000);
        chk("carry_synch_init", 32'(synch_init), 32'd9999);

        // Pause mid-period at 0042, then resume and switch direction
        init_val = 17'd42; ctr_select = 3'd0;
        step(1);
        ctr_select = 3'd1;
        step(6);
        count_en = 1'b0;
        step(500);
        chk_count("pause_hold", 16'h0042);
        count_en = 1'b1;
        step(3);
        chk_count("resume_before", 16'h0042);
        step(1);
        chk_count("resume_step", 16'h0043);
        step(5);
        ctr_select = 3'd2;
        step(4);
        chk_count("switch_before", 16'h0043);
        step(1);
        chk_count("switch_step", 16'h0042);
        ctr_select = 3'd5;
        step(30);
        chk_count("hold_sel5", 16'h0042);

        // Display of 1234 with scanning independent of count_en
        init_val = 17'd1234; ctr_select = 3'd0;
        step(1);
        ctr_select = 3'd7; count_en = 1'b0;
        step(2);
        digs = '{4, 3, 2, 1};
        for (int k = 0; k < 20; k++) begin
            step(1);
            d = ((edges - 1) / 4) % 4;
            chk("disp_an", 32'(an), 32'(~(4'b0001 << d) & 4'hF));
            chk("disp_sseg", 32'(sseg), 32'(exp_seg(digs[d])));
        end
        an_reset = 1'b1;
        step(1);
        chk("blank_an", 32'(an), 32'hF);
        chk("blank_sseg", 32'(sseg), 32'h7F);
        step(5);
        chk("blank_an_hold", 32'(an), 32'hF);
        an_reset = 1'b0;
        step(1);
        d = ((edges - 1) / 4) % 4;
        chk("unblank_an", 32'(an), 32'(~(4'b0001 << d) & 4'hF));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
